// File: rtl/mem_cmd_wb_bridge_pkg.sv
// Shared types for the MEM-stage command to Wishbone B4 classic bridge.
// State encoding and the default bus timeout.
package mem_cmd_wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_bridge_state_t;

  localparam int MEM_BRIDGE_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_cmd_wb_bridge_if.sv
// Command-side and Wishbone-side signal bundle for the bridge.
// master = the bridge itself, slave = the core plus the bus fabric.
interface mem_cmd_wb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
);

  logic                   MEM_CMD_START_I;
  logic                   MEM_CMD_WE_I;
  logic [ADDR_WIDTH-1:0]  MEM_CMD_ADDR_I;
  logic [BUS_WIDTH-1:0]   MEM_CMD_WDATA_I;
  logic [BUS_WIDTH/8-1:0] MEM_CMD_SEL_I;
  logic [BUS_WIDTH-1:0]   MEM_CMD_RDATA_O;
  logic                   MEM_CMD_BUSY_O;
  logic                   MEM_CMD_DONE_O;
  logic                   MEM_CMD_ERR_O;

  logic [ADDR_WIDTH-1:0]  WBM_ADR_O;
  logic [BUS_WIDTH-1:0]   WBM_DAT_O;
  logic [BUS_WIDTH-1:0]   WBM_DAT_I;
  logic [BUS_WIDTH/8-1:0] WBM_SEL_O;
  logic                   WBM_WE_O;
  logic                   WBM_CYC_O;
  logic                   WBM_STB_O;
  logic                   WBM_ACK_I;
  logic                   WBM_ERR_I;

  modport master (
    input  MEM_CMD_START_I,
    input  MEM_CMD_WE_I,
    input  MEM_CMD_ADDR_I,
    input  MEM_CMD_WDATA_I,
    input  MEM_CMD_SEL_I,
    output MEM_CMD_RDATA_O,
    output MEM_CMD_BUSY_O,
    output MEM_CMD_DONE_O,
    output MEM_CMD_ERR_O,
    output WBM_ADR_O,
    output WBM_DAT_O,
    input  WBM_DAT_I,
    output WBM_SEL_O,
    output WBM_WE_O,
    output WBM_CYC_O,
    output WBM_STB_O,
    input  WBM_ACK_I,
    input  WBM_ERR_I
  );

  modport slave (
    output MEM_CMD_START_I,
    output MEM_CMD_WE_I,
    output MEM_CMD_ADDR_I,
    output MEM_CMD_WDATA_I,
    output MEM_CMD_SEL_I,
    input  MEM_CMD_RDATA_O,
    input  MEM_CMD_BUSY_O,
    input  MEM_CMD_DONE_O,
    input  MEM_CMD_ERR_O,
    input  WBM_ADR_O,
    input  WBM_DAT_O,
    output WBM_DAT_I,
    input  WBM_SEL_O,
    input  WBM_WE_O,
    input  WBM_CYC_O,
    input  WBM_STB_O,
    output WBM_ACK_I,
    output WBM_ERR_I
  );

endinterface

// File: rtl/mem_cmd_wb_bridge_wb_timeout_counter.sv
// Wait-state counter for a stalled Wishbone cycle.
// expired is high once TIMEOUT_CYCLES-1 unterminated cycles have elapsed.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_cmd_wb_bridge.sv
// MEM-stage command responder issuing one Wishbone B4 classic cycle per command.
// Define MEM_BRIDGE_TIMEOUT_EN to abort stalled cycles after TIMEOUT_CYCLES.
module mem_cmd_wb_bridge
  import mem_cmd_wb_bridge_pkg::*;
#(
  parameter int WISHBONE_ADDR_WIDTH = 32,
  parameter int WISHBONE_BUS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES      = MEM_BRIDGE_TIMEOUT_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  mem_cmd_wb_bridge_if.master bus
);

  localparam int AW = WISHBONE_ADDR_WIDTH;
  localparam int DW = WISHBONE_BUS_WIDTH;
  localparam int SW = WISHBONE_BUS_WIDTH / 8;

  mem_bridge_state_t state_q, state_d;

  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [SW-1:0] sel_q, sel_d;

  logic in_req;
  logic term;
  logic tmo;

  assign in_req = (state_q == REQ);
  assign term   = bus.WBM_ACK_I | bus.WBM_ERR_I;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .CLK    (CLK),
    .RST    (RST),
    .enable (in_req & ~term),
    .clear  (~in_req),
    .expired(tmo)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        err_d  = 1'b0;
        cyc_d  = 1'b0;
        busy_d = 1'b0;
        if (bus.MEM_CMD_START_I) begin
          we_d    = bus.MEM_CMD_WE_I;
          adr_d   = bus.MEM_CMD_ADDR_I;
          dat_d   = bus.MEM_CMD_WDATA_I;
          sel_d   = bus.MEM_CMD_SEL_I;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // a real termination outranks a same-edge timeout
        if (term) begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = bus.WBM_ERR_I;
          rdata_d = (!we_q && !bus.WBM_ERR_I) ? bus.WBM_DAT_I : '0;
          state_d = RESP;
        end else if (tmo) begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.WBM_CYC_O       = cyc_q;
  assign bus.WBM_STB_O       = cyc_q;
  assign bus.WBM_WE_O        = we_q;
  assign bus.WBM_ADR_O       = adr_q;
  assign bus.WBM_DAT_O       = dat_q;
  assign bus.WBM_SEL_O       = sel_q;
  assign bus.MEM_CMD_BUSY_O  = busy_q;
  assign bus.MEM_CMD_DONE_O  = done_q;
  assign bus.MEM_CMD_ERR_O   = err_q;
  assign bus.MEM_CMD_RDATA_O = rdata_q;

endmodule

// File: tb/tb_mem_cmd_wb_bridge.sv
// Randomized bench for mem_cmd_wb_bridge against a memory-level reference.
// Define MEM_BRIDGE_TIMEOUT_EN to also cover the stalled-slave abort.
module tb_mem_cmd_wb_bridge;
  import mem_cmd_wb_bridge_pkg::*;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = MEM_BRIDGE_TIMEOUT_DEFAULT;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_cmd_wb_bridge_if #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) bus();

  mem_cmd_wb_bridge #(
    .WISHBONE_ADDR_WIDTH(32),
    .WISHBONE_BUS_WIDTH (32),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int errs = 0;
  int checks = 0;
  int exp_cycles = 0;
  int exp_dones = 0;
  int wb_cycles = 0;
  int dones = 0;
  logic cyc_prev = 1'b0;

  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] wd,
                                        logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.WBM_CYC_O && !cyc_prev) wb_cycles++;
    cyc_prev = bus.WBM_CYC_O;
    if (bus.MEM_CMD_DONE_O) dones++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_idle(string tag);
    check({tag, ".cyc"}, 32'(bus.WBM_CYC_O), 0);
    check({tag, ".busy"}, 32'(bus.MEM_CMD_BUSY_O), 0);
    check({tag, ".done"}, 32'(bus.MEM_CMD_DONE_O), 0);
  endtask

  // mode: 0=ACK, 1=ERR, 2=ACK+ERR, 3=never terminate
  task automatic do_cmd(bit we, logic [31:0] addr, logic [31:0] wd,
                        logic [3:0] sel, int waits, int mode, bit keep);
    int idx;
    int last;
    logic [31:0] rd_exp;
    logic [3:0] ix;
    idx  = int'(addr[5:2]);
    last = (mode == 3) ? TO - 1 : waits;
    bus.MEM_CMD_START_I = 1'b1;
    bus.MEM_CMD_WE_I    = we;
    bus.MEM_CMD_ADDR_I  = addr;
    bus.MEM_CMD_WDATA_I = wd;
    bus.MEM_CMD_SEL_I   = sel;
    bus.WBM_ACK_I       = 1'($urandom);
    bus.WBM_ERR_I       = 1'($urandom);
    exp_cycles++;
    @(negedge clk);
    for (int w = 0; w <= last; w++) begin
      check("req.cyc", 32'(bus.WBM_CYC_O), 1);
      check("req.stb", 32'(bus.WBM_STB_O), 1);
      check("req.busy", 32'(bus.MEM_CMD_BUSY_O), 1);
      check("req.done", 32'(bus.MEM_CMD_DONE_O), 0);
      check("req.adr", bus.WBM_ADR_O, addr);
      check("req.dat", bus.WBM_DAT_O, wd);
      check("req.sel", 32'(bus.WBM_SEL_O), 32'(sel));
      check("req.we", 32'(bus.WBM_WE_O), 32'(we));
      bus.MEM_CMD_START_I = keep ? 1'b1 : 1'($urandom);
      bus.WBM_DAT_I = $urandom;
      bus.WBM_ACK_I = 1'b0;
      bus.WBM_ERR_I = 1'b0;
      if (w == last && mode != 3) begin
        ix = bus.WBM_ADR_O[5:2];
        bus.WBM_ACK_I = (mode != 1);
        bus.WBM_ERR_I = (mode != 0);
        if (mode == 0 && !bus.WBM_WE_O) bus.WBM_DAT_I = slv_mem[ix];
        if (mode == 0 && bus.WBM_WE_O)
          slv_mem[ix] = merge(slv_mem[ix], bus.WBM_DAT_O, bus.WBM_SEL_O);
      end
      @(negedge clk);
    end
    rd_exp = (!we && mode == 0) ? ref_mem[idx] : 32'h0;
    if (we && mode == 0) ref_mem[idx] = merge(ref_mem[idx], wd, sel);
    exp_dones++;
    check("resp.done", 32'(bus.MEM_CMD_DONE_O), 1);
    check("resp.busy", 32'(bus.MEM_CMD_BUSY_O), 1);
    check("resp.err", 32'(bus.MEM_CMD_ERR_O), 32'(mode != 0));
    check("resp.rdata", bus.MEM_CMD_RDATA_O, rd_exp);
    check("resp.cyc", 32'(bus.WBM_CYC_O), 0);
    check("resp.stb", 32'(bus.WBM_STB_O), 0);
    bus.MEM_CMD_START_I = keep;
    bus.WBM_ACK_I = 1'($urandom);
    bus.WBM_ERR_I = 1'($urandom);
    @(negedge clk);
    check_idle("post");
    check("post.err", 32'(bus.MEM_CMD_ERR_O), 0);
    check("post.rdata", bus.MEM_CMD_RDATA_O, rd_exp);
    bus.WBM_ACK_I = 1'b0;
    bus.WBM_ERR_I = 1'b0;
  endtask

  task automatic check_reset_vals(string tag);
    check_idle(tag);
    check({tag, ".stb"}, 32'(bus.WBM_STB_O), 0);
    check({tag, ".we"}, 32'(bus.WBM_WE_O), 0);
    check({tag, ".err"}, 32'(bus.MEM_CMD_ERR_O), 0);
    check({tag, ".rdata"}, bus.MEM_CMD_RDATA_O, 0);
    check({tag, ".adr"}, bus.WBM_ADR_O, 0);
    check({tag, ".dat"}, bus.WBM_DAT_O, 0);
    check({tag, ".sel"}, 32'(bus.WBM_SEL_O), 0);
  endtask

  initial begin
    bit keep;
    bit prev_keep;
    int r;
    int mode;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    slv_mem[0] = 32'hDEADBEEF;
    ref_mem[0] = 32'hDEADBEEF;
    bus.MEM_CMD_START_I = 1'b0;
    bus.MEM_CMD_WE_I    = 1'b0;
    bus.MEM_CMD_ADDR_I  = '0;
    bus.MEM_CMD_WDATA_I = '0;
    bus.MEM_CMD_SEL_I   = '0;
    bus.WBM_DAT_I       = '0;
    bus.WBM_ACK_I       = 1'b0;
    bus.WBM_ERR_I       = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    do_cmd(1'b0, 32'h1000, 32'h0, 4'hF, 0, 0, 1'b0);
    do_cmd(1'b1, 32'h2004, 32'h12345678, 4'h3, 3, 0, 1'b0);
    do_cmd(1'b0, 32'h2004, 32'h0, 4'hF, 0, 0, 1'b0);
    do_cmd(1'b0, 32'h1008, 32'h0, 4'hF, 1, 2, 1'b0);

    do_cmd(1'b1, 32'h100C, 32'hA5A5_0F0F, 4'hF, 2, 0, 1'b1);
    do_cmd(1'b0, 32'h100C, 32'h0, 4'hF, 1, 0, 1'b1);
    do_cmd(1'b0, 32'h1010, 32'h0, 4'hF, 0, 1, 1'b0);

    bus.MEM_CMD_START_I = 1'b1;
    bus.MEM_CMD_WE_I    = 1'b0;
    bus.MEM_CMD_ADDR_I  = 32'h1014;
    exp_cycles++;
    @(negedge clk);
    bus.MEM_CMD_START_I = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_idle("afterrst");
    end

    prev_keep = 1'b0;
    for (int n = 0; n < 80; n++) begin
      keep = (n == 79) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
      if (!prev_keep) begin
        repeat ($urandom_range(0, 3)) begin
          bus.WBM_ACK_I = 1'($urandom);
          bus.WBM_ERR_I = 1'($urandom);
          @(negedge clk);
          check_idle("gap");
        end
        bus.WBM_ACK_I = 1'b0;
        bus.WBM_ERR_I = 1'b0;
      end
      r = $urandom_range(0, 7);
      mode = (r < 6) ? 0 : (r == 6) ? 1 : 2;
      do_cmd(1'($urandom), 32'h3000 | (32'($urandom_range(0, 15)) << 2),
             $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 4),
             mode, keep);
      prev_keep = keep;
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    do_cmd(1'b0, 32'h1018, 32'h0, 4'hF, 0, 3, 1'b0);
    do_cmd(1'b0, 32'h1018, 32'h0, 4'hF, 1, 0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("wb_cycles", 32'(wb_cycles), 32'(exp_cycles));
    check("done_pulses", 32'(dones), 32'(exp_dones));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
